// File: rtl/apb_led_ctrl.sv
// APB3 slave driving NUM_LED LEDs with per-LED static/blink/inverted-blink/PWM modes.
// Optional macro APB_LED_CTRL_PSLVERR_EN enables PSLVERR on unmapped or illegal accesses.
module apb_led_ctrl #(
    parameter int NUM_LED    = 8,
    parameter int PRESC_BITS = 16,
    parameter int PWM_BITS   = 8,
    parameter logic [NUM_LED-1:0] LED_RST = NUM_LED'(1)
) (
    input  logic               PCLK,
    input  logic               PRESETN,
    input  logic               PSEL,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [7:0]         PADDR,
    input  logic [31:0]        PWDATA,
    output logic [31:0]        PRDATA,
    output logic               PREADY,
    output logic               PSLVERR,
    output logic [NUM_LED-1:0] LED
);

    localparam logic [5:0] A_OUT    = 6'd0;
    localparam logic [5:0] A_MODE   = 6'd1;
    localparam logic [5:0] A_PERIOD = 6'd2;
    localparam logic [5:0] A_DUTY   = 6'd3;
    localparam logic [5:0] A_TOGGLE = 6'd4;
    localparam logic [5:0] A_STATUS = 6'd5;

    logic [NUM_LED-1:0]   out_reg;
    logic [2*NUM_LED-1:0] mode_reg;
    logic [PRESC_BITS-1:0] period_reg;
    logic [PWM_BITS-1:0]  duty_reg;
    logic [PRESC_BITS-1:0] presc_cnt;
    logic                 phase;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic                 pwm_on;
    logic [NUM_LED-1:0]   led_next;
    logic [5:0]           idx;
    logic                 wr;
    logic                 wr_ok;
    logic                 unused_ok;

    assign idx       = PADDR[7:2];
    assign wr        = PSEL & PENABLE & PWRITE;
    assign PREADY    = 1'b1;
    assign unused_ok = ^{PADDR[1:0], PWDATA};

`ifdef APB_LED_CTRL_PSLVERR_EN
    logic err_cond;
    assign err_cond = (idx > A_STATUS) | (PWRITE & (idx == A_STATUS)) | (~PWRITE & (idx == A_TOGGLE));
    assign PSLVERR  = PSEL & PENABLE & err_cond;
    assign wr_ok    = wr & ~err_cond;
`else
    assign PSLVERR  = 1'b0;
    assign wr_ok    = wr;
`endif

    // All-ones duty means fully on; otherwise the compare can never reach 100%.
    assign pwm_on = (&duty_reg) | (pwm_cnt < duty_reg);

    always_comb begin
        led_next = '0;
        for (int i = 0; i < NUM_LED; i++) begin
            case (mode_reg[2*i +: 2])
                2'b00:   led_next[i] = out_reg[i];
                2'b01:   led_next[i] = phase;
                2'b10:   led_next[i] = ~phase;
                default: led_next[i] = pwm_on;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            out_reg    <= LED_RST;
            mode_reg   <= '0;
            period_reg <= '0;
            duty_reg   <= '0;
            presc_cnt  <= '0;
            phase      <= 1'b0;
            pwm_cnt    <= '0;
            LED        <= LED_RST;
        end else begin
            if (wr_ok) begin
                case (idx)
                    A_OUT:    out_reg    <= PWDATA[NUM_LED-1:0];
                    A_MODE:   mode_reg   <= PWDATA[2*NUM_LED-1:0];
                    A_PERIOD: period_reg <= PWDATA[PRESC_BITS-1:0];
                    A_DUTY:   duty_reg   <= PWDATA[PWM_BITS-1:0];
                    A_TOGGLE: out_reg    <= out_reg ^ PWDATA[NUM_LED-1:0];
                    default:  ;
                endcase
            end
            // A PERIOD write restarts the blink timebase and beats a coincident wrap.
            if (wr_ok && idx == A_PERIOD) begin
                presc_cnt <= '0;
                phase     <= 1'b0;
            end else if (presc_cnt == period_reg) begin
                presc_cnt <= '0;
                phase     <= ~phase;
            end else begin
                presc_cnt <= presc_cnt + PRESC_BITS'(1);
            end
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            LED     <= led_next;
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            case (idx)
                A_OUT:    PRDATA[NUM_LED-1:0]    = out_reg;
                A_MODE:   PRDATA[2*NUM_LED-1:0]  = mode_reg;
                A_PERIOD: PRDATA[PRESC_BITS-1:0] = period_reg;
                A_DUTY:   PRDATA[PWM_BITS-1:0]   = duty_reg;
                A_STATUS: begin
                    PRDATA[NUM_LED-1:0] = LED;
                    PRDATA[16]          = phase;
                end
                default:  PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_led_ctrl.sv
// Scoreboard bench for apb_led_ctrl: APB responses and per-cycle LED values are queued
// by the stimulus and checked by an independent monitor on the falling edge.
module tb_apb_led_ctrl;

    logic        PCLK    = 1'b0;
    logic        PRESETN = 1'b0;
    logic        PSEL    = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE  = 1'b0;
    logic [7:0]  PADDR   = '0;
    logic [31:0] PWDATA  = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [7:0]  LED;

    apb_led_ctrl #(
        .NUM_LED(8), .PRESC_BITS(16), .PWM_BITS(8), .LED_RST(8'h01)
    ) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .LED(LED)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        bit          err;
        string       name;
    } apb_exp_t;

    typedef struct {
        int        at;
        logic [7:0] val;
        string     name;
    } led_exp_t;

    apb_exp_t apb_q[$];
    led_exp_t led_q[$];
    int checks = 0;
    int errors = 0;

    function automatic bit exp_err(bit w, logic [7:0] a);
`ifdef APB_LED_CTRL_PSLVERR_EN
        logic [5:0] ix;
        ix = a[7:2];
        return (ix > 6'd5) || (w && ix == 6'd5) || (!w && ix == 6'd4);
`else
        return 1'b0;
`endif
    endfunction

    task automatic apb(input bit w, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input string name);
        apb_exp_t e;
        e.is_rd = !w;
        e.data  = exp;
        e.err   = exp_err(w, a);
        e.name  = name;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
        apb_q.push_back(e);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic expect_led(input int at, input logic [7:0] v, input string name);
        led_exp_t l;
        l.at = at; l.val = v; l.name = name;
        led_q.push_back(l);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(posedge PCLK);
        #1;
    endtask

    apb_exp_t me;
    led_exp_t ml;
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            if (apb_q.size() == 0) begin
                errors++;
                $display("FAIL apb_unexpected: access at cycle %0d with no queued expectation", cyc);
            end else begin
                me = apb_q.pop_front();
                checks++;
                if (PSLVERR !== me.err || PREADY !== 1'b1) begin
                    errors++;
                    $display("FAIL %s: pslverr=%b pready=%b, required pslverr=%b pready=1",
                             me.name, PSLVERR, PREADY, me.err);
                end
                if (me.is_rd) begin
                    checks++;
                    if (PRDATA !== me.data) begin
                        errors++;
                        $display("FAIL %s: prdata=%h, required %h", me.name, PRDATA, me.data);
                    end
                end
            end
        end
        while (led_q.size() > 0 && led_q[0].at <= cyc) begin
            ml = led_q.pop_front();
            checks++;
            if (ml.at < cyc) begin
                errors++;
                $display("FAIL %s: check for cycle %0d missed (now %0d)", ml.name, ml.at, cyc);
            end else if (LED !== ml.val) begin
                errors++;
                $display("FAIL %s: cycle %0d led=%h, required %h", ml.name, cyc, LED, ml.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int rel, base, c0, ph;

    initial begin
        // Power-on reset: LED reflects LED_RST while still held in reset.
        @(posedge PCLK); #2;
        expect_led(cyc, 8'h01, "rst_led");
        @(posedge PCLK); #2;
        PRESETN = 1'b1;
        rel = cyc;

        apb(0, 8'h00, 0, 32'h01, "rst_out");
        apb(0, 8'h04, 0, 32'h00, "rst_mode");
        apb(0, 8'h08, 0, 32'h00, "rst_period");
        apb(0, 8'h0C, 0, 32'h00, "rst_duty");

        apb(1, 8'h00, 32'hA5, 0, "wr_out");
        expect_led(cyc + 1, 8'hA5, "led_static");
        apb(1, 8'h10, 32'h0F, 0, "wr_toggle");
        expect_led(cyc + 1, 8'hAA, "led_toggle");
        apb(0, 8'h00, 0, 32'hAA, "rd_out_toggled");
        apb(0, 8'h10, 0, 32'h00, "rd_toggle");

        // Blink on LED0 with 4-cycle half period.
        apb(1, 8'h04, 32'h1, 0, "wr_mode_blink");
        apb(1, 8'h08, 32'h3, 0, "wr_period3");
        base = cyc;
        for (int k = 1; k <= 12; k++)
            expect_led(base + k, (((k - 1) / 4) % 2 == 1) ? 8'hAB : 8'hAA, "blink");
        apb(0, 8'h14, 0, 32'h0000_00AA, "rd_status_blink");
        wait_until(base + 14);

        apb(1, 8'h04, 32'h2, 0, "wr_mode_invblink");
        c0 = cyc;
        for (int k = 1; k <= 8; k++)
            expect_led(c0 + k, (((c0 + k - 1 - base) / 4) % 2 == 1) ? 8'hAA : 8'hAB, "inv_blink");
        wait_until(c0 + 10);

        // Re-writing PERIOD mid-count restarts the phase at 0.
        apb(1, 8'h08, 32'h3, 0, "wr_period_mid");
        base = cyc;
        for (int k = 1; k <= 9; k++)
            expect_led(base + k, (((k - 1) / 4) % 2 == 1) ? 8'hAA : 8'hAB, "inv_blink_restart");
        apb(0, 8'h14, 0, 32'h0000_00AB, "rd_status_restart");
        wait_until(base + 12);

        // PWM on LED0; pwm_cnt after edge t is (t - rel) mod 256.
        apb(1, 8'h04, 32'h3, 0, "wr_mode_pwm");
        apb(1, 8'h0C, 32'd64, 0, "wr_duty64");
        c0 = cyc;
        for (int t = c0 + 1; t <= c0 + 256; t++)
            expect_led(t, (((t - 1 - rel) % 256) < 64) ? 8'hAB : 8'hAA, "pwm64");
        apb(0, 8'h0C, 0, 32'd64, "rd_duty");
        apb(0, 8'h08, 0, 32'd3, "rd_period");
        wait_until(c0 + 257);

        apb(1, 8'h0C, 32'd0, 0, "wr_duty0");
        c0 = cyc;
        for (int k = 1; k <= 260; k++) expect_led(c0 + k, 8'hAA, "pwm0");
        wait_until(c0 + 261);

        apb(1, 8'h0C, 32'd255, 0, "wr_duty255");
        c0 = cyc;
        for (int k = 1; k <= 260; k++) expect_led(c0 + k, 8'hAB, "pwm255");
        wait_until(c0 + 261);

        // Unmapped and illegal accesses.
        apb(0, 8'h40, 0, 32'h0, "rd_unmapped");
        apb(1, 8'h14, 32'hFFFF_FFFF, 0, "wr_status");
        c0 = cyc;
        ph = ((c0 + 2 - base) / 4) % 2;
        apb(0, 8'h14, 0, (ph == 1) ? 32'h0001_00AB : 32'h0000_00AB, "rd_status_after_wr");
        apb(1, 8'h40, 32'h55, 0, "wr_unmapped");
        apb(0, 8'h00, 0, 32'hAA, "rd_out_after_unmapped");
        apb(0, 8'h04, 0, 32'h3, "rd_mode_after_unmapped");

        // Asynchronous reset in the middle of blinking.
        apb(1, 8'h04, 32'h1, 0, "wr_mode_blink2");
        apb(1, 8'h08, 32'h2, 0, "wr_period2");
        repeat (5) @(posedge PCLK);
        #2;
        PRESETN = 1'b0;
        expect_led(cyc, 8'h01, "led_async_rst");
        @(posedge PCLK); #2;
        expect_led(cyc, 8'h01, "led_in_rst");
        PRESETN = 1'b1;
        rel = cyc;
        for (int k = 1; k <= 20; k++) expect_led(rel + k, 8'h01, "led_after_rst");
        apb(0, 8'h04, 0, 32'h0, "rd_mode_after_rst");
        apb(0, 8'h08, 0, 32'h0, "rd_period_after_rst");
        apb(0, 8'h00, 0, 32'h01, "rd_out_after_rst");
        apb(0, 8'h0C, 0, 32'h0, "rd_duty_after_rst");

        for (int i = 0; i < 600 && (apb_q.size() > 0 || led_q.size() > 0); i++)
            @(posedge PCLK);
        #1;
        if (apb_q.size() > 0 || led_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d apb and %0d led expectations left, required 0",
                     apb_q.size(), led_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
